// File: rtl/time_uart_reporter_if.sv
// Report bus for time_uart_reporter: the time word and request come in,
// the serial line and the status flags go out.
interface time_uart_reporter_if;
  logic [31:0] i_time_data;  // {hour, min, sec, msec}, binary, one byte each
  logic        i_send;       // report request
  logic        o_tx;         // UART serial line, idle high
  logic        o_busy;       // report in progress
  logic        o_done;       // one-cycle pulse after the last stop bit

  // Producer side (time source / testbench)
  modport master (
    output i_time_data,
    output i_send,
    input  o_tx,
    input  o_busy,
    input  o_done
  );

  // Reporter side
  modport slave (
    input  i_time_data,
    input  i_send,
    output o_tx,
    output o_busy,
    output o_done
  );
endinterface

// File: rtl/time_uart_reporter.sv
// time_uart_reporter: on request, snapshots the packed time word and sends
// "HH:MM:SS.CC\r\n" as 13 UART bytes (8N1, LSB first), BAUD_DIV clocks per bit.
// Fields of 100 or more are sent as "99".
// Optional build macro PERIODIC_REPORT_EN: a change of the seconds field also
// requests a report, and one request arriving mid-report is held as pending
// and started on the edge after o_done.
module time_uart_reporter #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  time_uart_reporter_if.slave  bus
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       LAST_BYTE = 4'd12;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       byte_idx;
  logic [2:0]       bit_idx;
  logic [31:0]      snapshot;
  logic [7:0]       cur_byte;
  logic [15:0]      hour_ascii, min_ascii, sec_ascii, msec_ascii;
  logic             go;

  // Two ASCII decimal digits {tens, ones} for a field, saturated to 99.
  function automatic logic [15:0] to_ascii(input logic [7:0] v);
    logic [6:0] sat;
    logic [3:0] tens;
    logic [3:0] ones;
    sat  = (v >= 8'd100) ? 7'd99 : v[6:0];
    tens = 4'(sat / 7'd10);
    ones = 4'(sat % 7'd10);
    return {4'h3, tens, 4'h3, ones};
  endfunction

`ifdef PERIODIC_REPORT_EN
  logic [7:0] prev_sec;
  logic       pending;
  logic       trigger;

  assign trigger = bus.i_send | (bus.i_time_data[15:8] != prev_sec);
  assign go      = trigger | pending;

  // Follow the seconds field every edge, reset included, so leaving reset
  // never looks like a seconds change.
  always_ff @(posedge clk) begin
    prev_sec <= bus.i_time_data[15:8];
  end

  // Hold at most one trigger seen mid-report; IDLE always consumes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (state == IDLE) begin
      pending <= 1'b0;
    end else if (trigger) begin
      pending <= 1'b1;
    end
  end
`else
  assign go = bus.i_send;
`endif

  // Pick the byte being sent from the snapshot and the byte index.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    cur_byte   = 8'h0A;
    hour_ascii = to_ascii(snapshot[31:24]);
    min_ascii  = to_ascii(snapshot[23:16]);
    sec_ascii  = to_ascii(snapshot[15:8]);
    msec_ascii = to_ascii(snapshot[7:0]);
    case (byte_idx)
      4'd0:    cur_byte = hour_ascii[15:8];
      4'd1:    cur_byte = hour_ascii[7:0];
      4'd2:    cur_byte = 8'h3A;
      4'd3:    cur_byte = min_ascii[15:8];
      4'd4:    cur_byte = min_ascii[7:0];
      4'd5:    cur_byte = 8'h3A;
      4'd6:    cur_byte = sec_ascii[15:8];
      4'd7:    cur_byte = sec_ascii[7:0];
      4'd8:    cur_byte = 8'h2E;
      4'd9:    cur_byte = msec_ascii[15:8];
      4'd10:   cur_byte = msec_ascii[7:0];
      4'd11:   cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  // Capture the time word when a report is accepted.
  // NOTE: pure data register, only meaningful after a capture, so it carries
  // no reset and stays out of the control reset path.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && go) begin
      snapshot <= bus.i_time_data;
    end
  end

  // Report sequencer: start / 8 data / stop per byte, 13 bytes back to back.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      byte_idx   <= '0;
      bit_idx    <= '0;
      bus.o_tx   <= 1'b1;
      bus.o_busy <= 1'b0;
      bus.o_done <= 1'b0;
    end else begin
      bus.o_done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (go) begin
            state      <= START;
            byte_idx   <= '0;
            bus.o_tx   <= 1'b0;
            bus.o_busy <= 1'b1;
          end
        end
        START: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            bus.o_tx <= cur_byte[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              bus.o_tx <= 1'b1;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              bus.o_tx <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (byte_idx == LAST_BYTE) begin
              state      <= IDLE;
              bus.o_busy <= 1'b0;
              bus.o_done <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              state    <= START;
              bus.o_tx <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_uart_reporter.sv
// Testbench for time_uart_reporter at CLK_FREQ=100, BAUD=10 (10 clocks/bit).
// A UART receiver process decodes o_tx and checks each byte against a queue
// of expected characters filled when a report is requested; the stimulus
// side also checks the line cycle by cycle against the ideal 8N1 waveform.
module tb_time_uart_reporter;

  localparam int BAUD_DIV = 10;
  localparam int FRAME    = 10 * BAUD_DIV;
  localparam int REPORT   = 13 * FRAME;

  logic clk = 1'b0;
  logic rst;
  time_uart_reporter_if bus();

  time_uart_reporter #(.CLK_FREQ(100), .BAUD(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_str [13];
  bit          aborted = 1'b0;
  int          poke_n[$];
  logic [31:0] poke_w[$];
  bit          poke_s[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference string: saturate each field to 99, split into decimal digits.
  task automatic make_string(input logic [31:0] w);
    int f;
    int v;
    int p;
    p = 0;
    for (int i = 0; i < 4; i++) begin
      f = int'(w[31-8*i -: 8]);
      v = (f > 99) ? 99 : f;
      exp_str[p]   = 8'(48 + v / 10);
      exp_str[p+1] = 8'(48 + v % 10);
      p += 2;
      if (i < 3) begin
        exp_str[p] = (i == 2) ? 8'h2E : 8'h3A;
        p++;
      end
    end
    exp_str[11] = 8'h0D;
    exp_str[12] = 8'h0A;
  endtask

  // Run one report. follow=1: no stimulus, the report is expected to start
  // on its own at the next edge. rst_at>=0 aborts with reset at that cycle.
  task automatic run_report(input logic [31:0] word, input bit send,
                            input bit follow, input bit hold, input int rst_at);
    int   bad;
    int   k;
    int   p;
    int   nb;
    logic e;
    bad = 0;
    make_string(word);
    nb = 0;
    for (int b = 0; b < 13; b++)
      if (rst_at < 0 || b * FRAME + 9 * BAUD_DIV + BAUD_DIV / 2 <= rst_at) nb++;
    for (int b = 0; b < nb; b++) exp_q.push_back(exp_str[b]);
    if (!follow) begin
      bus.i_time_data = word;
      bus.i_send      = send;
    end
    @(negedge clk);
    for (int n = 0; n <= REPORT; n++) begin
      if (n > 0) @(negedge clk);
      if (n < REPORT) begin
        k = n / FRAME;
        p = (n % FRAME) / BAUD_DIV;
        if (p == 0)      e = 1'b0;
        else if (p == 9) e = 1'b1;
        else             e = exp_str[k][p-1];
        if (bus.o_tx !== e || bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) bad++;
      end
      if (n == rst_at) begin
        rst = 1'b1;
        if ((rst_at % FRAME) < 9 * BAUD_DIV + BAUD_DIV / 2) aborted = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("wave_before_reset", bad, 0);
        check("tx_after_reset", bus.o_tx, 1);
        check("busy_after_reset", bus.o_busy, 0);
        check("done_after_reset", bus.o_done, 0);
        poke_n.delete(); poke_w.delete(); poke_s.delete();
        bus.i_send = 1'b0;
        return;
      end
      if (n < REPORT) begin
        bus.i_send = hold;
        if (poke_n.size() > 0 && poke_n[0] == n) begin
          bus.i_time_data = poke_w[0];
          if (poke_s[0]) bus.i_send = 1'b1;
          void'(poke_n.pop_front());
          void'(poke_w.pop_front());
          void'(poke_s.pop_front());
        end
      end
    end
    bus.i_send = 1'b0;
    check("wave", bad, 0);
    check("done_at_end", bus.o_done, 1);
    check("busy_at_end", bus.o_busy, 0);
    check("tx_at_end", bus.o_tx, 1);
    poke_n.delete(); poke_w.delete(); poke_s.delete();
  endtask

  // Line must stay idle for ncyc cycles.
  task automatic idle_cycles(input int ncyc);
    int bad;
    bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) bad++;
    end
    check("idle", bad, 0);
  endtask

  // UART receiver / scoreboard: decode each frame at bit centres.
  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    logic       st;
    logic       sp;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.o_tx === 1'b0) begin
        repeat (BAUD_DIV / 2) @(negedge clk);
        st = bus.o_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD_DIV) @(negedge clk);
          b[i] = bus.o_tx;
        end
        repeat (BAUD_DIV) @(negedge clk);
        sp = bus.o_tx;
        if (aborted) begin
          aborted = 1'b0;
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected_byte actual=0x%0h expected=none", b);
        end else begin
          e = exp_q.pop_front();
          check("rx_frame", {22'd0, sp, b, st}, {22'd0, 1'b1, e, 1'b0});
        end
      end
    end
  end

  // Stimulus
  initial begin : stimulus
    logic [31:0] w;
    logic [31:0] pw;
    rst             = 1'b1;
    bus.i_send      = 1'b0;
    bus.i_time_data = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_tx", bus.o_tx, 1);
    check("reset_busy", bus.o_busy, 0);
    check("reset_done", bus.o_done, 0);
    rst = 1'b0;
    idle_cycles(20);

    // Reference report, cycle-exact line and o_done timing.
    run_report(32'h0C1E2D07, 1'b1, 1'b0, 1'b0, -1);
    idle_cycles(5);

    // Input changes mid-report must not alter the bytes sent.
`ifdef PERIODIC_REPORT_EN
    poke_n.push_back(200); poke_w.push_back(32'h00002D00); poke_s.push_back(1'b0);
`else
    poke_n.push_back(200); poke_w.push_back(32'h00000000); poke_s.push_back(1'b1);
`endif
    run_report(32'h0C1E2D07, 1'b1, 1'b0, 1'b0, -1);
    idle_cycles(5);

    // Saturation of 127 and 100.
    run_report(32'h7F3B6400, 1'b1, 1'b0, 1'b0, -1);
    idle_cycles(5);

`ifndef PERIODIC_REPORT_EN
    // i_send held through the o_done edge: still exactly one report.
    run_report(32'h17002A63, 1'b1, 1'b0, 1'b1, -1);
    idle_cycles(20);
`endif

    // Reset mid-report, then a fresh complete report.
    run_report(32'h0C1E2D07, 1'b1, 1'b0, 1'b0, 549);
    idle_cycles(100);
    run_report(32'h173B3B63, 1'b1, 1'b0, 1'b0, -1);
    idle_cycles(5);

`ifdef PERIODIC_REPORT_EN
    // Seconds tick starts a report; two more ticks mid-report give one more,
    // starting right after o_done.
    run_report(32'h01020500, 1'b1, 1'b0, 1'b0, -1);
    idle_cycles(5);
    poke_n.push_back(300); poke_w.push_back(32'h01020700); poke_s.push_back(1'b0);
    poke_n.push_back(600); poke_w.push_back(32'h01020800); poke_s.push_back(1'b0);
    run_report(32'h01020600, 1'b0, 1'b0, 1'b0, -1);
    run_report(32'h01020800, 1'b0, 1'b1, 1'b0, -1);
    idle_cycles(200);
`else
    // Seconds changes alone never start a report.
    bus.i_time_data = 32'h01020500;
    idle_cycles(20);
    bus.i_time_data = 32'h01020600;
    idle_cycles(200);
`endif

    // Randomized reports with a random mid-report disturbance.
    for (int r = 0; r < 6; r++) begin
      w  = {8'($urandom_range(0, 130)), 8'($urandom_range(0, 130)),
            8'($urandom_range(0, 130)), 8'($urandom_range(0, 130))};
      pw = $urandom;
`ifdef PERIODIC_REPORT_EN
      pw[15:8] = w[15:8];
      poke_n.push_back(int'($urandom_range(1, REPORT - 1)));
      poke_w.push_back(pw);
      poke_s.push_back(1'b0);
`else
      poke_n.push_back(int'($urandom_range(1, REPORT - 1)));
      poke_w.push_back(pw);
      poke_s.push_back(1'b1);
`endif
      run_report(w, 1'b1, 1'b0, 1'b0, -1);
      idle_cycles(1 + int'($urandom_range(0, 3)));
    end

    idle_cycles(50);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
